pipelined_function_unit: RTL

- Registered, parametrised successor to the CPU datapath function unit (ALU + shifter).
- Accepts an operation through a valid/ready handshake and returns F with Z/C/N/V/N_xor_V flags through a held output register.
- Single-cycle operations have 1-cycle latency; an optional iterative shift-add multiply takes WIDTH cycles.
- Sits between the register-file read buses and the write-back mux.

---
 rtl/fu_pkg.sv | 21 ++
 rtl/fu_comb_alu.sv | 57 +++++
 rtl/pipelined_function_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/fu_pkg.sv
// fu_pkg: function-select codes and FSM encoding shared by the function unit and its bench
package fu_pkg;
  localparam logic [4:0] FS_TSA     = 5'd0;
  localparam logic [4:0] FS_INC     = 5'd1;
  localparam logic [4:0] FS_ADD     = 5'd2;
  localparam logic [4:0] FS_ADDC    = 5'd3;
  localparam logic [4:0] FS_SUBB    = 5'd4;
  localparam logic [4:0] FS_SUB     = 5'd5;
  localparam logic [4:0] FS_DEC     = 5'd6;
  localparam logic [4:0] FS_TSA_ALT = 5'd7;
  localparam logic [4:0] FS_AND     = 5'd8;
  localparam logic [4:0] FS_OR      = 5'd9;
  localparam logic [4:0] FS_XOR     = 5'd10;
  localparam logic [4:0] FS_NOT     = 5'd11;
  localparam logic [4:0] FS_TSB     = 5'd12;
  localparam logic [4:0] FS_SRL     = 5'd13;
  localparam logic [4:0] FS_SLL     = 5'd14;
  localparam logic [4:0] FS_SRA     = 5'd15;
  localparam logic [4:0] FS_MUL     = 5'd16;
  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
endpackage

// File: rtl/fu_comb_alu.sv
// fu_comb_alu: combinational single-cycle datapath (arithmetic, logic, shifts) producing F, C and V
module fu_comb_alu
  import fu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SH_W-1:0]  sh,
  input  logic [4:0]       fs,
  output logic [WIDTH-1:0] f,
  output logic             c,
  output logic             v
);
  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum, srl_x, sll_x, sra_x;
  // shifts run one bit wider so the last bit shifted out lands in the extra bit (0 when sh==0)
  always_comb begin
    b_op  = fs == FS_INC ? '0 : (fs == FS_ADD || fs == FS_ADDC) ? b : fs == FS_DEC ? '1 : ~b;
    cin   = fs == FS_INC || fs == FS_ADDC || fs == FS_SUB;
    sum   = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    srl_x = {b, 1'b0} >> sh;
    sll_x = {1'b0, b} << sh;
    sra_x = $signed({b, 1'b0}) >>> sh;
    f = '0;
    c = 1'b0;
    v = 1'b0;
    case (fs)
      FS_TSA, FS_TSA_ALT: f = a;
      FS_INC, FS_ADD, FS_ADDC, FS_SUBB, FS_SUB, FS_DEC: begin
        f = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      FS_AND: f = a & b;
      FS_OR:  f = a | b;
      FS_XOR: f = a ^ b;
      FS_NOT: f = ~a;
      FS_TSB: f = b;
      FS_SRL: begin
        f = srl_x[WIDTH:1];
        c = srl_x[0];
      end
      FS_SLL: begin
        f = sll_x[WIDTH-1:0];
        c = sll_x[WIDTH];
      end
      FS_SRA: begin
        f = sra_x[WIDTH:1];
        c = sra_x[0];
      end
      default: f = '0;
    endcase
  end
endmodule

// File: rtl/pipelined_function_unit.sv
// pipelined_function_unit: registered ALU/shifter with valid/ready handshake and held result register
// Define FU_MULTIPLY_EN to enable the iterative shift-add multiply on FS=16 (otherwise FS=16 is reserved).
module pipelined_function_unit
  import fu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Bus_A,
  input  logic [WIDTH-1:0] Bus_B,
  input  logic [SH_W-1:0]  SH,
  input  logic [4:0]       FS,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Z,
  output logic             C,
  output logic             N,
  output logic             V,
  output logic             N_xor_V
);
  logic [WIDTH-1:0] alu_f, f_n;
  logic             alu_c, alu_v, c_n, v_n, accept, load;
  fu_comb_alu #(.WIDTH(WIDTH), .SH_W(SH_W)) u_alu (
    .a (Bus_A),
    .b (Bus_B),
    .sh(SH),
    .fs(FS),
    .f (alu_f),
    .c (alu_c),
    .v (alu_v)
  );
  assign accept = in_valid && in_ready;
`ifdef FU_MULTIPLY_EN
  localparam int CNT_W = $clog2(WIDTH);
  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, mcand, prod;
  logic [WIDTH-1:0]   mplier;
  logic               is_mul, mul_done;
  assign is_mul   = FS == FS_MUL;
  assign prod     = acc + (mplier[0] ? mcand : '0);
  assign mul_done = state == ST_MUL && cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_n;
  always_comb state_n = state == ST_IDLE ? ((accept && is_mul) ? ST_MUL : ST_IDLE) : (mul_done ? ST_IDLE : ST_MUL);
  always_comb in_ready = state == ST_IDLE && (!out_valid || out_ready);
  // one multiplier bit per cycle; prod is the running sum including the current bit
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, Bus_A};
      mplier <= Bus_B;
    end else if (state == ST_MUL) begin
      cnt    <= cnt + 1'b1;
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  assign load = (accept && !is_mul) || mul_done;
  assign f_n  = mul_done ? prod[WIDTH-1:0] : alu_f;
  assign c_n  = mul_done ? |prod[2*WIDTH-1:WIDTH] : alu_c;
  assign v_n  = mul_done ? 1'b0 : alu_v;
`else
  assign in_ready = !out_valid || out_ready;
  assign load     = accept;
  assign f_n      = alu_f;
  assign c_n      = alu_c;
  assign v_n      = alu_v;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      F         <= '0;
      Z         <= 1'b0;
      C         <= 1'b0;
      N         <= 1'b0;
      V         <= 1'b0;
      N_xor_V   <= 1'b0;
    end else begin
      out_valid <= load || (out_valid && !out_ready);
      if (load) begin
        F       <= f_n;
        Z       <= f_n == '0;
        C       <= c_n;
        N       <= f_n[WIDTH-1];
        V       <= v_n;
        N_xor_V <= f_n[WIDTH-1] ^ v_n;
      end
    end
endmodule
